// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared types, constants and index helpers for the 3-requester round-robin mux arbiter.
// The optional burst limit is enabled with the MUX3_ARB_BURST_LIMIT_EN macro (see top).
package mux3_rr_arbiter_pkg;

   typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam int         ARB_NREQ = 3;
   localparam logic [1:0] SEL_D0   = 2'd0;
   localparam logic [1:0] SEL_D1   = 2'd1;
   localparam logic [1:0] SEL_D2   = 2'd2;

   function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         SEL_D0:  oh = 3'b001;
         SEL_D1:  oh = 3'b010;
         SEL_D2:  oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   // Successor modulo the requester count.
   function automatic logic [1:0] idx_next(input logic [1:0] idx);
      return (idx == SEL_D2) ? SEL_D0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/mux3_rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the mux arbiter.
// master = arbiter side, slave = requester/mux side.
interface mux3_rr_arbiter_if #(
   parameter int MAX_BURST = 8
);
   localparam int CNT_W = $clog2(MAX_BURST);

   logic [2:0]       req_in;
   logic [1:0]       sel_out;
   logic [2:0]       gnt_out;
   logic             gnt_valid_out;
   logic [CNT_W-1:0] burst_cnt_out;

   modport master (
      input  req_in,
      output sel_out, gnt_out, gnt_valid_out, burst_cnt_out
   );

   modport slave (
      output req_in,
      input  sel_out, gnt_out, gnt_valid_out, burst_cnt_out
   );
endinterface

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// Combinational round-robin picker: first bit of (req & mask) scanning ptr, ptr+1, ptr+2 mod 3.
module rr_pick3
   import mux3_rr_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   input  logic [2:0] mask,
   output logic       found,
   output logic [1:0] idx
);
   logic [2:0] cand;
   logic [2:0] rot;
   logic [1:0] base;

   assign cand = req & mask;
   assign base = (ptr == 2'd3) ? SEL_D0 : ptr;

   // rot[o] is the candidate at scan offset o from base.
   always_comb begin
      case (base)
         SEL_D1:  rot = {cand[0], cand[2], cand[1]};
         SEL_D2:  rot = {cand[1], cand[0], cand[2]};
         default: rot = cand;
      endcase
   end

   assign found = |rot;

   always_comb begin
      if (rot[0])
         idx = base;
      else if (rot[1])
         idx = idx_next(base);
      else
         idx = idx_next(idx_next(base));
   end
endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter driving the 3x16 operand mux select and a one-hot registered grant.
// Define MUX3_ARB_BURST_LIMIT_EN to preempt an owner after MAX_BURST cycles when others wait.
module mux3_rr_arbiter
   import mux3_rr_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic               clk,
   input  logic               rst,
   mux3_rr_arbiter_if.master  bus
);
   localparam int               CNT_W     = $clog2(MAX_BURST);
   localparam logic [CNT_W-1:0] BURST_TOP = CNT_W'(MAX_BURST - 1);

   arb_state_t       state_reg, state_next;
   logic [1:0]       ptr_reg, ptr_next;
   logic [1:0]       owner_reg, owner_next;
   logic [CNT_W-1:0] burst_reg, burst_next;
   logic [2:0]       gnt_reg, gnt_next;
   logic [1:0]       sel_reg, sel_next;
   logic             valid_reg, valid_next;

   logic       pick_found;
   logic [1:0] pick_idx;
   logic [2:0] pick_mask;
   logic       take;

   // While granted, the current owner is never a candidate for re-arbitration.
   assign pick_mask = (state_reg == ARB_GRANT) ? ~idx_onehot(owner_reg) : 3'b111;

   rr_pick3 u_pick (
      .req   (bus.req_in),
      .ptr   (ptr_reg),
      .mask  (pick_mask),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      owner_next = owner_reg;
      burst_next = burst_reg;
      gnt_next   = gnt_reg;
      sel_next   = sel_reg;
      valid_next = valid_reg;
      take       = 1'b0;

      case (state_reg)
         ARB_IDLE: begin
            if (pick_found)
               take = 1'b1;
         end
         ARB_GRANT: begin
            if (!bus.req_in[owner_reg]) begin
               if (pick_found) begin
                  take = 1'b1;
               end else begin
                  state_next = ARB_IDLE;
                  gnt_next   = 3'b000;
                  valid_next = 1'b0;
                  burst_next = '0;
               end
            end else if (burst_reg == BURST_TOP) begin
`ifdef MUX3_ARB_BURST_LIMIT_EN
               if (pick_found)
                  take = 1'b1;
               else
                  burst_next = '0;
`endif
            end else begin
               burst_next = burst_reg + 1'b1;
            end
         end
         default: state_next = ARB_IDLE;
      endcase

      if (take) begin
         state_next = ARB_GRANT;
         owner_next = pick_idx;
         gnt_next   = idx_onehot(pick_idx);
         sel_next   = pick_idx;
         valid_next = 1'b1;
         ptr_next   = idx_next(pick_idx);
         burst_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ARB_IDLE;
         ptr_reg   <= SEL_D0;
         owner_reg <= SEL_D0;
         burst_reg <= '0;
         gnt_reg   <= 3'b000;
         sel_reg   <= SEL_D0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         owner_reg <= owner_next;
         burst_reg <= burst_next;
         gnt_reg   <= gnt_next;
         sel_reg   <= sel_next;
         valid_reg <= valid_next;
      end
   end

   assign bus.gnt_out       = gnt_reg;
   assign bus.sel_out       = sel_reg;
   assign bus.gnt_valid_out = valid_reg;
   assign bus.burst_cnt_out = burst_reg;
endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: directed scenarios plus randomized requests
// compared every cycle against a behavioural round-robin model.
module tb_mux3_rr_arbiter;
   localparam int MAX_BURST = 8;
   localparam int CNT_W     = $clog2(MAX_BURST);
`ifdef MUX3_ARB_BURST_LIMIT_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mux3_rr_arbiter_if #(.MAX_BURST(MAX_BURST)) bus ();

   mux3_rr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      int owner;  // -1 when idle
      int ptr;
      int cnt;
      int sel;
   } mstate_t;

   mstate_t m = '{owner: -1, ptr: 0, cnt: 0, sel: 0};

   function automatic int pick(input logic [2:0] r, input int start, input int skip);
      for (int o = 0; o < 3; o++) begin
         int i = (start + o) % 3;
         if (i != skip && r[i]) return i;
      end
      return -1;
   endfunction

   function automatic mstate_t grant_to(input mstate_t s, input int n);
      mstate_t t = s;
      t.owner = n;
      t.ptr   = (n + 1) % 3;
      t.cnt   = 0;
      t.sel   = n;
      return t;
   endfunction

   function automatic mstate_t step(input mstate_t s, input logic [2:0] r);
      mstate_t t = s;
      int n;
      if (s.owner < 0) begin
         n = pick(r, s.ptr, -1);
         if (n >= 0) t = grant_to(s, n);
      end else if (!r[s.owner]) begin
         n = pick(r, (s.owner + 1) % 3, s.owner);
         if (n >= 0) t = grant_to(s, n);
         else begin t.owner = -1; t.cnt = 0; end
      end else if (BURST_EN && s.cnt == MAX_BURST - 1) begin
         n = pick(r, (s.owner + 1) % 3, s.owner);
         if (n >= 0) t = grant_to(s, n);
         else t.cnt = 0;
      end else if (s.cnt < MAX_BURST - 1) begin
         t.cnt = s.cnt + 1;
      end
      return t;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '{owner: -1, ptr: 0, cnt: 0, sel: 0};
      else     m <= step(m, bus.req_in);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model comparison on every falling edge.
   always @(negedge clk) begin
      int eg;
      eg = (m.owner < 0) ? 0 : (1 << m.owner);
      check("model_gnt",   int'(bus.gnt_out), eg);
      check("model_valid", int'(bus.gnt_valid_out), (m.owner >= 0) ? 1 : 0);
      check("model_sel",   int'(bus.sel_out), m.sel);
      check("model_burst", int'(bus.burst_cnt_out), (m.owner < 0) ? 0 : m.cnt);
   end

   task automatic do_reset(input logic [2:0] r);
      @(negedge clk);
      #2 rst = 1'b1;
      bus.req_in = r;
      repeat (2) begin
         @(negedge clk);
         check("rst_gnt",   int'(bus.gnt_out), 0);
         check("rst_sel",   int'(bus.sel_out), 0);
         check("rst_valid", int'(bus.gnt_valid_out), 0);
      end
      #2 rst = 1'b0;
      bus.req_in = 3'b000;
   endtask

   int order [6] = '{0, 1, 2, 0, 1, 2};

   initial begin
      bus.req_in = 3'b000;
      #1 rst = 1'b1;

      // Reset with all requests high
      do_reset(3'b111);
      $display("txn reset: outputs idle under req=111");

      // Single requester
      @(negedge clk) bus.req_in = 3'b010;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         check("single_gnt", int'(bus.gnt_out), 3'b010);
         check("single_sel", int'(bus.sel_out), 1);
         if (c == 5) bus.req_in = 3'b000;
      end
      @(negedge clk);
      check("single_idle", int'(bus.gnt_valid_out), 0);
      check("single_sel_hold", int'(bus.sel_out), 1);
      $display("txn single: requester 1 served 5 cycles");

      // Round-robin with drops after two granted cycles
      do_reset(3'b000);
      @(negedge clk) bus.req_in = 3'b111;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         check("rr_first", int'(bus.gnt_out), 1 << order[n]);
         bus.req_in = 3'b111;
         @(negedge clk);
         check("rr_second", int'(bus.gnt_out), 1 << order[n]);
         bus.req_in = 3'b111 & ~(3'b001 << order[n]);
      end
      $display("txn round_robin: order 0,1,2,0,1,2");

      // Handover collision
      do_reset(3'b000);
      @(negedge clk) bus.req_in = 3'b100;
      @(negedge clk);
      check("coll_own2", int'(bus.gnt_out), 3'b100);
      bus.req_in = 3'b011;
      @(negedge clk);
      check("coll_gnt", int'(bus.gnt_out), 3'b001);
      check("coll_sel", int'(bus.sel_out), 0);
      $display("txn collision: owner 2 hands over to 0");

      // Burst limit
      do_reset(3'b000);
      @(negedge clk) bus.req_in = 3'b001;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         check("burst_hold", int'(bus.gnt_out), 3'b001);
         check("burst_cnt", int'(bus.burst_cnt_out), j - 1);
         if (j == 2) bus.req_in = 3'b011;
      end
      @(negedge clk);
      check("burst_after8", int'(bus.gnt_out), BURST_EN ? 3'b010 : 3'b001);
      $display("txn burst: limit_en=%0d gnt=%b", BURST_EN, bus.gnt_out);

      // Asynchronous reset while owner 1 granted
      do_reset(3'b000);
      @(negedge clk) bus.req_in = 3'b010;
      @(negedge clk);
      check("midrst_own1", int'(bus.gnt_out), 3'b010);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_gnt", int'(bus.gnt_out), 0);
      check("midrst_valid", int'(bus.gnt_valid_out), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      bus.req_in = 3'b011;
      @(negedge clk);
      check("midrst_first", int'(bus.gnt_out), 3'b001);
      $display("txn midrst: grant dropped, restart at 0");

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) bus.req_in = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end
         if (c % 500 == 0) $display("txn random: cycle %0d req=%b gnt=%b", c, bus.req_in, bus.gnt_out);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
